// File: rtl/rand_num_pkg.sv
// Shared constants for the rand_num generator: LFSR widths, feedback tap masks
// and default seeds.
package rand_num_pkg;

  localparam int A_WIDTH = 16;
  localparam int B_WIDTH = 15;

  // A tap bit is set for every state bit that feeds the XOR feedback.
  localparam logic [15:0] A_TAPS = 16'hB400;  // bits 15,13,12,10
  localparam logic [14:0] B_TAPS = 15'h6000;  // bits 14,13

  localparam logic [15:0] A_SEED_DEF = 16'hACE1;
  localparam logic [14:0] B_SEED_DEF = 15'h1234;

  // Output tap shared by both LFSRs for the low bit of the random value.
  localparam int MID_BIT = 7;

endpackage

// File: rtl/lfsr_fib.sv
// Generic Fibonacci LFSR that shifts left every clock and injects the parity
// of the tapped bits into bit 0.
module lfsr_fib #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] o_state
);

  // An all-zero state would never leave zero, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_NZ =
    (SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  logic [WIDTH-1:0] r_state;
  logic             w_fb;

  // Feedback bit from the tapped state bits.
  always_comb begin
    w_fb = ^(r_state & TAPS);
  end

  // State register, seeded asynchronously while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_NZ;
    end else begin
      r_state <= {r_state[WIDTH-2:0], w_fb};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/rand_num.sv
// Two-bit pseudo-random source built from two coprime-period LFSRs whose bits
// are XOR-combined into a registered output.
module rand_num
  import rand_num_pkg::*;
#(
  parameter logic [A_WIDTH-1:0] SEED_A = A_SEED_DEF,
  parameter logic [B_WIDTH-1:0] SEED_B = B_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] o_rand
);

  logic [A_WIDTH-1:0] w_a;
  logic [B_WIDTH-1:0] w_b;
  logic [1:0]         w_rand_nxt;
  logic [1:0]         r_rand;

  lfsr_fib #(
    .WIDTH (A_WIDTH),
    .TAPS  (A_TAPS),
    .SEED  (SEED_A)
  ) u_lfsr_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_state (w_a)
  );

  lfsr_fib #(
    .WIDTH (B_WIDTH),
    .TAPS  (B_TAPS),
    .SEED  (SEED_B)
  ) u_lfsr_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_state (w_b)
  );

  // Combine the current (pre-shift) LFSR states into the next output value.
  always_comb begin
    w_rand_nxt = {w_a[A_WIDTH-1] ^ w_b[B_WIDTH-1], w_a[MID_BIT] ^ w_b[MID_BIT]};
  end

  // Output register keeps the value stable between edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rand <= 2'b00;
    end else begin
      r_rand <= w_rand_nxt;
    end
  end

  assign o_rand = r_rand;

endmodule

// File: tb/tb_rand_num.sv
// Self-checking bench for rand_num against an arithmetic reference model of
// the two LFSRs, with reset, period, distribution and mid-run reset checks.
module tb_rand_num;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] o_rand;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state and cycle count since last reset release.
  int unsigned m_a;
  int unsigned m_b;
  int unsigned m_rand;
  int          n_since;
  int          cnt [4];

  rand_num dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_rand (o_rand)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned bit_of(input int unsigned v, input int pos);
    return (v >> pos) & 1;
  endfunction

  task automatic model_reset();
    m_a = 32'hACE1;
    m_b = 32'h1234;
    m_rand = 0;
    n_since = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  // One clock: model advances at the rising edge, DUT checked at the falling edge.
  task automatic step();
    int unsigned fa;
    int unsigned fb;
    @(posedge clk);
    m_rand = ((bit_of(m_a, 15) ^ bit_of(m_b, 14)) * 2) + (bit_of(m_a, 7) ^ bit_of(m_b, 7));
    fa = bit_of(m_a, 15) ^ bit_of(m_a, 13) ^ bit_of(m_a, 12) ^ bit_of(m_a, 10);
    fb = bit_of(m_b, 14) ^ bit_of(m_b, 13);
    m_a = (m_a * 2 + fa) % 65536;
    m_b = (m_b * 2 + fb) % 32768;
    n_since++;
    @(negedge clk);
    chk("rand", {30'd0, o_rand}, m_rand);
    chk("lfsr_a", {16'd0, dut.w_a}, m_a);
    chk("lfsr_b", {17'd0, dut.w_b}, m_b);
    chk("a_nonzero", {31'd0, dut.w_a != 16'd0}, 32'd1);
    chk("b_nonzero", {31'd0, dut.w_b != 15'd0}, 32'd1);
    if (n_since <= 65536) cnt[o_rand]++;
    if (n_since == 32767) chk("period_b", {17'd0, dut.w_b}, 32'h1234);
    if (n_since == 65535) chk("period_a", {16'd0, dut.w_a}, 32'hACE1);
    if (n_since == 65536) begin
      for (int v = 0; v < 4; v++) begin
        $display("rand value %0d seen %0d times", v, cnt[v]);
        chk("distribution", {31'd0, (cnt[v] >= 15872) && (cnt[v] <= 16896)}, 32'd1);
      end
    end
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("reset_rand", {30'd0, o_rand}, 32'd0);
    chk("reset_a", {16'd0, dut.w_a}, 32'hACE1);
    chk("reset_b", {17'd0, dut.w_b}, 32'h1234);
    @(negedge clk);
    rst_n = 1'b1;

    step();
    chk("edge1_rand", {30'd0, o_rand}, 32'd3);
    chk("edge1_a", {16'd0, dut.w_a}, 32'h59C3);
    chk("edge1_b", {17'd0, dut.w_b}, 32'h2468);
    step();
    chk("edge2_rand", {30'd0, o_rand}, 32'd1);

    for (int i = 0; i < 998 + int'($urandom_range(0, 7)); i++) step();

    // Asynchronous reset pulse between edges must clear the output at once.
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rand", {30'd0, o_rand}, 32'd0);
    chk("midrst_a", {16'd0, dut.w_a}, 32'hACE1);
    chk("midrst_b", {17'd0, dut.w_b}, 32'h1234);
    #1 rst_n = 1'b1;
    model_reset();
    step();
    chk("midrst_edge1", {30'd0, o_rand}, 32'd3);
    step();
    chk("midrst_edge2", {30'd0, o_rand}, 32'd1);

    for (int i = 0; i < 99000; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rand_num.md
RAND_NUM -- requirements
Module: rand_num

Interface
REQ-001 SHALL have parameter SEED_A, default 16'hACE1, reset value of 16-bit LFSR A.
REQ-002 SHALL have parameter SEED_B, default 15'h1234, reset value of 15-bit LFSR B.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rand  output  2  registered pseudo-random value, new value every clock.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-007 SHALL hold LFSR A (16 bit, Fibonacci): fbA = a[15]^a[13]^a[12]^a[10]; next a = {a[14:0], fbA}; period 65535.
REQ-008 SHALL hold LFSR B (15 bit, Fibonacci): fbB = b[14]^b[13]; next b = {b[13:0], fbB}; period 32767.
REQ-009 SHALL advance both LFSRs every rising clk edge while rst_n high, no enable or stall.
REQ-010 SHALL update rand each rising edge to {a[15]^b[14], a[7]^b[7]} using pre-shift (current) LFSR values.
REQ-011 SHALL provide combined sequence period 65535*32767 = 2147385345 cycles (coprime periods).
REQ-012 SHALL replace an all-zero seed parameter by value 1 at elaboration, so the LFSR can never lock up.
REQ-013 SHALL drive rand only from flops, no combinational path from any input to rand.
REQ-014 SHALL allow consumers to sample rand combinationally any time; rand is stable between clock edges.

Reset
REQ-015 SHALL, while rst_n low, force a=SEED_A, b=SEED_B, rand=2'b00 immediately, independent of clk.
REQ-016 SHALL, on rst_n deassertion, produce its first new rand at the first following rising clk edge.
REQ-017 SHALL restart the identical sequence after any reset, including reset asserted mid-operation.

Structure
REQ-018 SHALL place tap masks, widths and default seeds in shared package rand_num_pkg.
REQ-019 SHALL implement each LFSR as one instance of sub-module lfsr_fib, parameterised by width, tap mask, seed.
REQ-020 SHALL keep the output XOR-combine and rand register in rand_num top.

Verification
REQ-021 SHALL test reset: rst_n low, no clock -> rand=2'b00, a=16'hACE1, b=15'h1234.
REQ-022 SHALL test first edges after reset release: edge1 -> rand=2'b11, a=16'h59C3, b=15'h2468; edge2 -> rand=2'b01.
REQ-023 SHALL test period: after 65535 clocks a returns to 16'hACE1; after 32767 clocks b returns to 15'h1234; neither ever zero.
REQ-024 SHALL test mid-run async reset: pulse rst_n low between edges after 1000 cycles -> rand=00 at once; next two edges reproduce 11, 01.
REQ-025 SHALL test distribution: 65536 cycles after reset -> each rand value count within 16384 +/- 512.
REQ-026 SHALL compare every cycle against a bit-accurate reference model for at least 100000 cycles with zero mismatches.
